fft_iter: RTL

Parametrised iterative radix-2 decimation-in-time FFT engine. It is the next-generation replacement for the fixed 4-point FFT core and supports any power-of-two transform size. Samples stream in over a valid/ready port and are stored in bit-reversed order. A single shared butterfly then processes log2(NPTS) stages, and results stream out in natural order over a valid/ready port. The engine sits between the sample-capture front end and the spectral post-processing blocks.

---
 rtl/fft_iter_if.sv | 28 ++
 rtl/fft_iter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_iter_if.sv
// Streaming port bundle for fft_iter: sample input, bin output and busy status.
// The engine connects through the slave modport; the feeding logic uses master.
interface fft_iter_if #(
  parameter int NPTS = 8,
  parameter int DW   = 16
);
  localparam int AW = $clog2(NPTS);

  logic              in_valid;
  logic              in_ready;
  logic [2*DW-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [2*DW-1:0]   out_data;
  logic [AW-1:0]     out_index;
  logic              out_last;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, busy
  );
endinterface

// File: rtl/fft_iter.sv
// fft_iter: iterative radix-2 DIT FFT with one shared butterfly, bit-reversed load and natural-order unload.
// Build option FFT_ITER_SCALE_EN: halve every butterfly output; otherwise saturate and track overflow.
module fft_iter #(
  parameter int NPTS = 8,
  parameter int DW   = 16
) (
  input  logic      clk,
  input  logic      rst,
  fft_iter_if.slave bus
);
  localparam int AW = $clog2(NPTS);
  localparam int HN = NPTS / 2;
  localparam int FX = 30;
  localparam longint FX_ONE = longint'(1) << FX;
  localparam longint PI_FX  = 64'sd3373259426;
  localparam logic signed [DW+1:0] SAT_MAX = (DW+2)'((longint'(1) << (DW-1)) - 1);
  localparam logic signed [DW+1:0] SAT_MIN = (DW+2)'(-(longint'(1) << (DW-1)));
  localparam logic signed [2*DW:0] RND     = (2*DW+1)'(longint'(1) << (DW-2));
  localparam logic [AW-2:0] J_LAST = '1;
  localparam logic [AW-1:0] N_LAST = '1;
  localparam logic [AW-1:0] S_LAST = AW'(AW-1);

  // Fixed-point (2^30) Taylor series; arguments stay within [0, pi/2].
  function automatic longint fx_cos(input longint th);
    longint sum, term;
    sum  = FX_ONE;
    term = FX_ONE;
    for (int i = 1; i <= 12; i++) begin
      term = -((((term * th) >>> FX) * th) >>> FX) / longint'((2*i-1) * (2*i));
      sum += term;
    end
    return sum;
  endfunction

  function automatic longint fx_sin(input longint th);
    longint sum, term;
    sum  = th;
    term = th;
    for (int i = 1; i <= 12; i++) begin
      term = -((((term * th) >>> FX) * th) >>> FX) / longint'((2*i) * (2*i+1));
      sum += term;
    end
    return sum;
  endfunction

  function automatic longint quant(input longint v);
    longint half, lim, q;
    half = longint'(1) << (FX - DW);
    lim  = (longint'(1) << (DW-1)) - 1;
    if (v >= 0) q = (v + half) >>> (FX + 1 - DW);
    else        q = -((-v + half) >>> (FX + 1 - DW));
    if (q > lim)  q = lim;
    if (q < -lim) q = -lim;
    return q;
  endfunction

  // Entry k = {cos, -sin} of 2*pi*k/NPTS; angles past pi/2 are folded via pi - theta.
  function automatic logic [HN*2*DW-1:0] build_twiddle();
    logic [HN*2*DW-1:0] rom;
    longint th, c, s, qc, qs;
    int m;
    rom = '0;
    for (int k = 0; k < HN; k++) begin
      m  = (2*k <= HN) ? k : HN - k;
      th = (2 * PI_FX * m) / NPTS;
      c  = fx_cos(th);
      s  = fx_sin(th);
      if (2*k > HN) c = -c;
      qc = quant(c);
      qs = quant(-s);
      rom[k*2*DW +: 2*DW] = {qc[DW-1:0], qs[DW-1:0]};
    end
    return rom;
  endfunction

  function automatic logic [DW-1:0] sat(input logic signed [DW+1:0] v);
    if (v > SAT_MAX)      return DW'(SAT_MAX);
    else if (v < SAT_MIN) return DW'(SAT_MIN);
    else                  return DW'(v);
  endfunction

  localparam logic [HN*2*DW-1:0] TW_ROM = build_twiddle();

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   cnt_reg, cnt_next;
  logic [AW-1:0]   stage_reg, stage_next;
  logic [AW-2:0]   j_reg, j_next;
  logic            ld_en, bf_en;
  logic [2*DW-1:0] mem [NPTS];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stage_next = stage_reg;
    j_next     = j_reg;
    ld_en      = 1'b0;
    bf_en      = 1'b0;
    case (state_reg)
      LOAD: begin
        if (bus.in_valid) begin
          ld_en    = 1'b1;
          cnt_next = cnt_reg + AW'(1);
          if (cnt_reg == N_LAST) state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        bf_en  = 1'b1;
        j_next = j_reg + (AW-1)'(1);
        if (j_reg == J_LAST) begin
          if (stage_reg == S_LAST) begin
            stage_next = '0;
            state_next = UNLOAD;
          end else begin
            stage_next = stage_reg + AW'(1);
          end
        end
      end
      UNLOAD: begin
        if (bus.out_ready) begin
          cnt_next = cnt_reg + AW'(1);
          if (cnt_reg == N_LAST) state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LOAD;
      cnt_reg   <= '0;
      stage_reg <= '0;
      j_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      stage_reg <= stage_next;
      j_reg     <= j_next;
    end
  end

  logic [AW-1:0] load_addr, j_ext, h, lo, a_addr, b_addr;
  logic [AW-2:0] tw_k;

  for (genvar gi = 0; gi < AW; gi++) begin : g_bitrev
    assign load_addr[gi] = cnt_reg[AW-1-gi];
  end

  logic signed [DW-1:0] tw_re_rom [HN];
  logic signed [DW-1:0] tw_im_rom [HN];

  for (genvar gi = 0; gi < HN; gi++) begin : g_twiddle
    assign tw_re_rom[gi] = TW_ROM[gi*2*DW + DW +: DW];
    assign tw_im_rom[gi] = TW_ROM[gi*2*DW +: DW];
  end

  assign j_ext  = {1'b0, j_reg};
  assign h      = AW'(1) << stage_reg;
  assign lo     = j_ext & (h - AW'(1));
  assign a_addr = ((j_ext >> stage_reg) << (stage_reg + AW'(1))) | lo;
  assign b_addr = a_addr | h;
  assign tw_k   = (AW-1)'(lo << (S_LAST - stage_reg));

  logic signed [DW-1:0]   a_re, a_im, b_re, b_im, w_re, w_im;
  logic signed [2*DW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [2*DW:0]   s_re, s_im;
  logic signed [DW+1:0]   t_re, t_im, sa_re, sa_im, sb_re, sb_im;
  logic signed [DW-1:0]   na_re, na_im, nb_re, nb_im;

  assign {a_re, a_im} = mem[a_addr];
  assign {b_re, b_im} = mem[b_addr];
  assign w_re = tw_re_rom[tw_k];
  assign w_im = tw_im_rom[tw_k];

  assign p_rr = (2*DW)'(w_re) * (2*DW)'(b_re);
  assign p_ii = (2*DW)'(w_im) * (2*DW)'(b_im);
  assign p_ri = (2*DW)'(w_re) * (2*DW)'(b_im);
  assign p_ir = (2*DW)'(w_im) * (2*DW)'(b_re);
  assign s_re = (2*DW+1)'(p_rr) - (2*DW+1)'(p_ii);
  assign s_im = (2*DW+1)'(p_ri) + (2*DW+1)'(p_ir);

  // Unit twiddle skips the multiplier so W*B is exact.
  assign t_re = (tw_k == '0) ? (DW+2)'(b_re) : (DW+2)'((s_re + RND) >>> (DW-1));
  assign t_im = (tw_k == '0) ? (DW+2)'(b_im) : (DW+2)'((s_im + RND) >>> (DW-1));

  assign sa_re = (DW+2)'(a_re) + t_re;
  assign sa_im = (DW+2)'(a_im) + t_im;
  assign sb_re = (DW+2)'(a_re) - t_re;
  assign sb_im = (DW+2)'(a_im) - t_im;

`ifdef FFT_ITER_SCALE_EN
  assign na_re = sat(sa_re >>> 1);
  assign na_im = sat(sa_im >>> 1);
  assign nb_re = sat(sb_re >>> 1);
  assign nb_im = sat(sb_im >>> 1);
`else
  assign na_re = sat(sa_re);
  assign na_im = sat(sa_im);
  assign nb_re = sat(sb_re);
  assign nb_im = sat(sb_im);

  logic ovf_any;
  logic ovf_reg;

  assign ovf_any = (sa_re > SAT_MAX) || (sa_re < SAT_MIN) || (sa_im > SAT_MAX) || (sa_im < SAT_MIN) ||
                   (sb_re > SAT_MAX) || (sb_re < SAT_MIN) || (sb_im > SAT_MAX) || (sb_im < SAT_MIN);

  // Debug-only sticky flag; a new frame starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          ovf_reg <= 1'b0;
    else if (state_next == LOAD && state_reg != LOAD) ovf_reg <= 1'b0;
    else if (bf_en && ovf_any)                        ovf_reg <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (ld_en) mem[load_addr] <= bus.in_data;
    if (bf_en) begin
      mem[a_addr] <= {na_re, na_im};
      mem[b_addr] <= {nb_re, nb_im};
    end
  end

  // RAM is frozen during UNLOAD, so a stalled beat stays stable without an output register.
  assign bus.in_ready  = (state_reg == LOAD);
  assign bus.out_valid = (state_reg == UNLOAD);
  assign bus.busy      = (state_reg != LOAD);
  assign bus.out_data  = (state_reg == UNLOAD) ? mem[cnt_reg] : '0;
  assign bus.out_index = (state_reg == UNLOAD) ? cnt_reg : '0;
  assign bus.out_last  = (state_reg == UNLOAD) && (cnt_reg == N_LAST);
endmodule
